// File: rtl/mac_rx_buffer_wr_pkg.sv
// rtl/mac_rx_buffer_wr_pkg.sv - shared types and descriptor layout for the rx frame buffer writer
package mac_rx_buffer_wr_pkg;

    localparam int AW_DEFAULT        = 12;
    localparam int MAX_WORDS_DEFAULT = 1520;
    localparam int LEN_LSB           = 0;
    localparam int LEN_W             = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DROP   = 2'd3
    } rx_state_e;

    function automatic logic [63:0] make_desc(input logic [LEN_W-1:0] byte_len);
        logic [63:0] w;
        w = '0;
        w[LEN_LSB +: LEN_W] = byte_len;
        return w;
    endfunction

endpackage

// File: rtl/mac_rx_buffer_wr_rx_byte_count.sv
// rtl/mac_rx_buffer_wr_rx_byte_count.sv - byte count of one contiguous 8-bit rx byte-enable word
module mac_rx_buffer_wr_rx_byte_count (
    input  logic [7:0] data_valid,
    output logic [3:0] byte_cnt
);

    always_comb begin
        byte_cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            byte_cnt = byte_cnt + {3'd0, data_valid[i]};
        end
    end

endmodule

// File: rtl/mac_rx_buffer_wr.sv
// rtl/mac_rx_buffer_wr.sv - packs MAC rx frames into a circular buffer as descriptor + data words
module mac_rx_buffer_wr
    import mac_rx_buffer_wr_pkg::*;
#(
    parameter int AW        = AW_DEFAULT,
    parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
    input  logic          mac_clk,
    input  logic          mac_rst,
    input  logic [63:0]   mac_rx_data,
    input  logic [7:0]    mac_rx_data_valid,
    input  logic          mac_rx_good_frame,
    input  logic          mac_rx_bad_frame,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [63:0]   wr_data,
    output logic [AW-1:0] committed_addr,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   frames_good,
    output logic [31:0]   frames_dropped
);

    localparam logic [LEN_W-1:0] MAX_W = LEN_W'(MAX_WORDS);

    rx_state_e        state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    start_q, start_d;
    logic [AW-1:0]    committed_q, committed_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [63:0]      wr_data_q, wr_data_d;
    logic             wr_en_q, wr_en_d;
    logic             pend_q, pend_d;
    logic [LEN_W-1:0] byte_len_q, byte_len_d;
    logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
    logic [31:0]      good_q, good_d;
    logic [31:0]      dropped_q, dropped_d;

    logic [3:0]       byte_cnt;
    logic             word_in, frame_end, in_frame, no_room;
    logic [AW-1:0]    next_addr;
    logic [LEN_W-1:0] cnt_next, len_base;

    mac_rx_buffer_wr_rx_byte_count u_rx_byte_count (
        .data_valid (mac_rx_data_valid),
        .byte_cnt   (byte_cnt)
    );

    assign word_in   = |mac_rx_data_valid;
    assign frame_end = mac_rx_good_frame | mac_rx_bad_frame;
    assign next_addr = wr_ptr_q + AW'(1);
    assign in_frame  = (state_q == ST_RECV) || ((state_q == ST_IDLE) && word_in);
    assign cnt_next  = (state_q == ST_IDLE) ? LEN_W'(1) : word_cnt_q + LEN_W'(1);
    assign len_base  = (state_q == ST_IDLE) ? '0 : byte_len_q;
    assign no_room   = (next_addr == rd_addr) || (cnt_next > MAX_W);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        start_d     = start_q;
        committed_d = committed_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        pend_d      = 1'b0;
        byte_len_d  = byte_len_q;
        word_cnt_d  = word_cnt_q;
        good_d      = good_q;
        dropped_d   = dropped_q;

        // Publishing one cycle after the descriptor write keeps the RAM ahead of the consumer.
        if (pend_q) begin
            committed_d = start_q;
            good_d      = good_q + 32'd1;
        end

        case (state_q)
            ST_IDLE, ST_RECV: begin
                if (word_in && !no_room) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = next_addr;
                    wr_data_d  = mac_rx_data;
                    wr_ptr_d   = next_addr;
                    byte_len_d = len_base + LEN_W'(byte_cnt);
                    word_cnt_d = cnt_next;
                end
                if (in_frame) begin
                    if (mac_rx_bad_frame || (frame_end && word_in && no_room)) begin
                        wr_ptr_d  = start_q;
                        dropped_d = dropped_q + 32'd1;
                        state_d   = ST_IDLE;
                    end else if (word_in && no_room) begin
                        state_d = ST_DROP;
                    end else if (mac_rx_good_frame) begin
                        state_d = ST_COMMIT;
                    end else begin
                        state_d = ST_RECV;
                    end
                end
            end
            ST_COMMIT: begin
                wr_en_d   = 1'b1;
                wr_addr_d = start_q;
                wr_data_d = make_desc(byte_len_q);
                wr_ptr_d  = next_addr;
                start_d   = next_addr;
                pend_d    = 1'b1;
                state_d   = word_in ? ST_DROP : ST_IDLE;
            end
            ST_DROP: begin
                if (frame_end) begin
                    wr_ptr_d  = start_q;
                    dropped_d = dropped_q + 32'd1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge mac_clk or posedge mac_rst) begin
        if (mac_rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            start_q     <= '0;
            committed_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            pend_q      <= 1'b0;
            byte_len_q  <= '0;
            word_cnt_q  <= '0;
            good_q      <= '0;
            dropped_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            start_q     <= start_d;
            committed_q <= committed_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            pend_q      <= pend_d;
            byte_len_q  <= byte_len_d;
            word_cnt_q  <= word_cnt_d;
            good_q      <= good_d;
            dropped_q   <= dropped_d;
        end
    end

    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_data        = wr_data_q;
    assign committed_addr = committed_q;
    assign frames_good    = good_q;
    assign frames_dropped = dropped_q;

endmodule
